muldiv_iter: RTL and testbench

- Iterative RV32M/RV64M multiply/divide unit for the EX stage; successor to the single-cycle multiply-only unit.
- Adds DIV/DIVU/REM/REMU, parametrised XLEN and bits-per-cycle, and valid/ready handshakes on both sides so the core can stall on it.
- Also adds a kill input so branch/jump flushes can abandon an in-flight operation.

---
 rtl/muldiv_iter.sv | 194 +++++++++++++++++++
 tb/tb_muldiv_iter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - iterative RV32M/RV64M multiply/divide unit with valid/ready and kill
// Sign-magnitude datapath: magnitudes are iterated, signs are applied once in FIX.
module muldiv_iter #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      funct3,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int N  = XLEN / UNROLL;
  localparam int CW = $clog2(N + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;

  state_t state_q, state_d;

  logic [XLEN-1:0] a_q, a_d, b_q, b_d, magb_q, magb_d, result_q, result_d;
  logic [2:0]      op_q, op_d;
  logic            sa_q, sa_d, sb_q, sb_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*XLEN:0] acc_q, acc_d, acc_step;

  logic            accept, is_div, a_signed, b_signed, sa_w, sb_w, special;
  logic [XLEN-1:0] mag_a, mag_b, spec_res, fix_res, quo_s, rem_s;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN:0]   rem_t, sum_t;
  logic [XLEN-1:0] lo_t;

  assign is_div = op_q[2];

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (op_q)
      3'b000, 3'b001, 3'b100, 3'b110: begin a_signed = 1'b1; b_signed = 1'b1; end
      3'b010:                         a_signed = 1'b1;
      default: ;
    endcase
  end

  assign sa_w  = a_signed & a_q[XLEN-1];
  assign sb_w  = b_signed & b_q[XLEN-1];
  assign mag_a = sa_w ? -a_q : a_q;
  assign mag_b = sb_w ? -b_q : b_q;

  // Divide-by-zero and signed overflow bypass the iteration entirely.
  always_comb begin
    special  = 1'b0;
    spec_res = '0;
    if (is_div && b_q == '0) begin
      special  = 1'b1;
      spec_res = op_q[1] ? a_q : '1;
    end else if (is_div && !op_q[0] && a_q == MIN_NEG && b_q == '1) begin
      special  = 1'b1;
      spec_res = op_q[1] ? '0 : a_q;
    end
  end

  // Multiply: carry-save-free shift-add, product builds from the top down.
  // Divide: restoring step, remainder in the upper half, quotient shifts into the lower.
  always_comb begin
    acc_step = acc_q;
    rem_t    = '0;
    lo_t     = '0;
    sum_t    = '0;
    for (int i = 0; i < UNROLL; i++) begin
      if (is_div) begin
        rem_t = {acc_step[2*XLEN-1:XLEN], acc_step[XLEN-1]};
        lo_t  = {acc_step[XLEN-2:0], 1'b0};
        if (rem_t >= {1'b0, magb_q}) begin
          rem_t   = rem_t - {1'b0, magb_q};
          lo_t[0] = 1'b1;
        end
        acc_step = {rem_t, lo_t};
      end else begin
        sum_t    = acc_step[2*XLEN:XLEN] + (acc_step[0] ? {1'b0, magb_q} : {(XLEN+1){1'b0}});
        acc_step = {1'b0, sum_t, acc_step[XLEN-1:1]};
      end
    end
  end

  assign prod_s = (sa_q ^ sb_q) ? -acc_q[2*XLEN-1:0] : acc_q[2*XLEN-1:0];
  assign quo_s  = (sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem_s  = sa_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  always_comb begin
    case (op_q)
      3'b000:                 fix_res = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res = quo_s;
      default:                fix_res = rem_s;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (kill) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (accept) state_d = S_PREP;
        S_PREP: state_d = special ? S_DONE : S_CALC;
        S_CALC: if (cnt_q == CW'(1)) state_d = S_FIX;
        S_FIX:  state_d = S_DONE;
        S_DONE: if (out_ready) state_d = accept ? S_PREP : S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = ~kill & ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));
    out_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
  end

  assign accept = in_valid & in_ready;
  assign result = result_q;

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    magb_d   = magb_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    if (accept) begin
      a_d  = a;
      b_d  = b;
      op_d = funct3;
    end
    case (state_q)
      S_PREP: begin
        sa_d   = sa_w;
        sb_d   = sb_w;
        magb_d = mag_b;
        acc_d  = {{(XLEN+1){1'b0}}, mag_a};
        cnt_d  = CW'(N);
        if (special && !kill) result_d = spec_res;
      end
      S_CALC: begin
        acc_d = acc_step;
        cnt_d = cnt_q - 1'b1;
      end
      S_FIX:   if (!kill) result_d = fix_res;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      magb_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      magb_q   <= magb_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
// tb/tb_muldiv_iter.sv - directed bench for muldiv_iter with a cycle-level reference model
module tb_muldiv_iter;

  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_valid4 = 1'b0;
  logic        kill = 1'b0, out_ready = 1'b1;
  logic [31:0] a = '0, b = '0;
  logic [2:0]  funct3 = '0;
  logic        in_ready, out_valid, busy, in_ready4, out_valid4, busy4;
  logic [31:0] result, result4;

  int checks = 0, errors = 0;

  muldiv_iter #(.XLEN(32), .UNROLL(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .funct3(funct3), .kill(kill), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  muldiv_iter #(.XLEN(32), .UNROLL(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4), .a(a), .b(b),
    .funct3(funct3), .kill(kill), .out_valid(out_valid4), .out_ready(out_ready),
    .result(result4), .busy(busy4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, ux, uy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'h0, x});
    uy = longint'({32'h0, y});
    p  = '0;
    case (op)
      3'b000: begin p = sx * sy; return p[31:0]; end
      3'b001: begin p = sx * sy; return p[63:32]; end
      3'b010: begin p = sx * uy; return p[63:32]; end
      3'b011: begin p = ux * uy; return p[63:32]; end
      3'b100: begin
        if (y == 0) return 32'hFFFFFFFF;
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return x;
        p = sx / sy; return p[31:0];
      end
      3'b101: begin
        if (y == 0) return 32'hFFFFFFFF;
        p = ux / uy; return p[31:0];
      end
      3'b110: begin
        if (y == 0) return x;
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h0;
        p = sx % sy; return p[31:0];
      end
      default: begin
        if (y == 0) return x;
        p = ux % uy; return p[31:0];
      end
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    if (op[2] && (y == 0 || (!op[0] && x == 32'h80000000 && y == 32'hFFFFFFFF))) return 1;
    return 34;
  endfunction

  // Transaction-level model of the UNROLL=1 unit: one pending op, due a fixed number of edges after accept.
  int          ecount = 0, due = 0;
  bit          pending = 1'b0, vm, rm, vc;
  logic [31:0] exp_res = '0, shown = '0;

  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      pending = 1'b0;
      shown   = '0;
    end else begin
      vm = pending && ecount >= due;
      rm = !kill && (!pending || (vm && out_ready));
      if (kill) pending = 1'b0;
      else begin
        if (vm && out_ready) pending = 1'b0;
        if (in_valid && rm) begin
          pending = 1'b1;
          exp_res = ref_res(funct3, a, b);
          due     = ecount + 1 + lat_of(funct3, a, b);
        end
      end
    end
    ecount++;
    if (pending && ecount == due) shown = exp_res;
  end

  initial forever begin
    @(negedge clk);
    #2;
    if (rst_n) begin
      vc = pending && ecount >= due;
      chk("cyc out_valid", out_valid, vc);
      chk("cyc busy", busy, pending);
      chk("cyc in_ready", in_ready, !kill && (!pending || (vc && out_ready)));
      chk("cyc result", result, shown);
    end
  end

  task automatic issue(input bit u4, input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    funct3 = op;
    a      = x;
    b      = y;
    if (u4) in_valid4 = 1'b1;
    else    in_valid  = 1'b1;
  endtask

  task automatic wait_valid(input bit u4, input logic [31:0] exp, input int exp_lat, input string name);
    int k = 0;
    bit seen = 1'b0;
    while (!seen && k < 200) begin
      @(negedge clk);
      in_valid  = 1'b0;
      in_valid4 = 1'b0;
      #2;
      k++;
      seen = u4 ? out_valid4 : out_valid;
    end
    if (!seen) chk({name, " timeout"}, 64'd0, 64'd1);
    else begin
      chk({name, " latency"}, 64'(k - 1), 64'(exp_lat));
      chk({name, " result"}, u4 ? result4 : result, exp);
    end
  endtask

  localparam int NV = 18;
  logic [2:0]  t_op  [NV] = '{3'b001, 3'b010, 3'b011, 3'b000, 3'b100, 3'b110, 3'b101, 3'b111, 3'b110,
                              3'b100, 3'b110, 3'b101, 3'b100, 3'b110, 3'b001, 3'b101, 3'b111, 3'b100};
  logic [31:0] t_a   [NV] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00010000, 32'hFFFFFFF9, 32'hFFFFFFF9,
                              32'd100, 32'd100, 32'd7, 32'd5, 32'd5, 32'd0, 32'h80000000, 32'h80000000,
                              32'hFFFFFFFD, 32'hFFFFFFFF, 32'd0, 32'h80000000};
  logic [31:0] t_b   [NV] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00010000, 32'd2, 32'd2,
                              32'd7, 32'd7, 32'hFFFFFFFE, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'd7, 32'd1, 32'd0, 32'd2};
  logic [31:0] t_exp [NV] = '{32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h0, 32'hFFFFFFFD, 32'hFFFFFFFF,
                              32'd14, 32'd2, 32'd1, 32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'h80000000, 32'h0,
                              32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'hC0000000};
  int          t_lat [NV] = '{34, 34, 34, 34, 34, 34, 34, 34, 34, 1, 1, 1, 1, 1, 34, 34, 1, 34};

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk("reset out_valid", out_valid, 1'b0);
    chk("reset busy", busy, 1'b0);
    chk("reset in_ready", in_ready, 1'b1);
    chk("reset result", result, 32'h0);

    @(negedge clk);
    issue(1'b0, 3'b000, 32'd7, 32'hFFFFFFFD);
    wait_valid(1'b0, 32'hFFFFFFEB, 34, "mul 7*-3");
    @(negedge clk);
    #2;
    chk("after retire busy", busy, 1'b0);
    chk("after retire in_ready", in_ready, 1'b1);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      issue(1'b0, t_op[i], t_a[i], t_b[i]);
      wait_valid(1'b0, t_exp[i], t_lat[i], $sformatf("vec%0d", i));
    end

    // Backpressure, then retire and accept on the same edge.
    @(negedge clk);
    out_ready = 1'b0;
    issue(1'b0, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_valid(1'b0, 32'hFFFFFFFE, 34, "bp first");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #2;
      chk("bp out_valid", out_valid, 1'b1);
      chk("bp result", result, 32'hFFFFFFFE);
      chk("bp in_ready", in_ready, 1'b0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    issue(1'b0, 3'b101, 32'd9, 32'd3);
    wait_valid(1'b0, 32'd3, 34, "bp second");

    // Kill in CALC cycle 10 with a competing request.
    @(negedge clk);
    issue(1'b0, 3'b100, 32'd100, 32'd7);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    kill = 1'b1;
    issue(1'b0, 3'b101, 32'd9, 32'd3);
    #2;
    chk("kill in_ready", in_ready, 1'b0);
    @(negedge clk);
    kill     = 1'b0;
    in_valid = 1'b0;
    #2;
    chk("post kill in_ready", in_ready, 1'b1);
    chk("post kill busy", busy, 1'b0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #2;
      chk("post kill out_valid", out_valid, 1'b0);
    end

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    issue(1'b0, 3'b000, 32'd3, 32'd5);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async rst out_valid", out_valid, 1'b0);
    chk("async rst result", result, 32'h0);
    chk("async rst busy", busy, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk("post rst in_ready", in_ready, 1'b1);

    // UNROLL=4 instance.
    @(negedge clk);
    issue(1'b1, 3'b000, 32'd7, 32'hFFFFFFFD);
    wait_valid(1'b1, 32'hFFFFFFEB, 10, "u4 mul");
    @(negedge clk);
    issue(1'b1, 3'b100, 32'hFFFFFFF9, 32'd2);
    wait_valid(1'b1, 32'hFFFFFFFD, 10, "u4 div");
    @(negedge clk);
    issue(1'b1, 3'b110, 32'd7, 32'hFFFFFFFE);
    wait_valid(1'b1, 32'd1, 10, "u4 rem");
    @(negedge clk);
    issue(1'b1, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_valid(1'b1, 32'hFFFFFFFE, 10, "u4 mulhu");
    @(negedge clk);
    issue(1'b1, 3'b100, 32'd5, 32'd0);
    wait_valid(1'b1, 32'hFFFFFFFF, 1, "u4 div0");

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
